hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-channel branch/load RAW checker.
- Keeps a shift-register scoreboard of in-flight register writes for the stages after decode.
- Compares every source operand of the instruction in decode against that scoreboard and produces one stall.
- Supports forwarding and non-forwarding pipelines, early-resolving branch consumers, flush, downstream hold, and a saturating stall counter.

Parameters:
- REG_ADDR_W, 3: register-number width.
- NUM_SRC, 2: source operands checked per instruction.
- DEPTH, 3: tracked stages after decode; entry 0 is the youngest (EX), entry DEPTH-1 is the oldest.
- FWD_EN, 1: 1 = forwarding datapath, so only load-use and branch-early stalls apply; 0 = stall on any match.
- FLUSH_STAGES, 1: number of youngest entries invalidated by flush (1..DEPTH).
- CNT_W, 16: stall counter width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous, active-low reset.
- issue_valid, in, 1: decode instruction is valid.
- issue_wr_en, in, 1: decode instruction writes a register.
- issue_wr_reg, in, REG_ADDR_W: destination register.
- issue_is_load, in, 1: decode instruction is a load.
- src_valid, in, NUM_SRC: per-source read-enable.
- src_reg, in, NUM_SRC*REG_ADDR_W: source registers; source i is bits [i*REG_ADDR_W +: REG_ADDR_W].
- src_is_branch, in, 1: decode instruction is a branch or register jump and needs its operands in decode.
- flush, in, 1: squash the youngest FLUSH_STAGES entries.
- pipe_hold, in, 1: downstream is frozen; the scoreboard holds.
- stall, out, 1: combinational; hold fetch/decode and inject a bubble.
- match_stage, out, log2(DEPTH) (min 1): entry index that caused the stall; 0 when stall=0.
- stall_count, out, CNT_W: saturating count of stall cycles.

Behaviour:
- Entry fields: {vld, wr, reg, ld}.
- Reset (rst_n=0 at a posedge): all vld=0, stall_count=0. stall and match_stage therefore evaluate to 0.
- Per-source match: the youngest entry k with vld & wr & (reg==src_reg[i]) & src_valid[i].
  - Older matching entries are ignored, because the newer write supersedes them.
  - A source with no match needs no stall.
- Stall rule for the matched entry k:
  - FWD_EN=0: stall for any k.
  - FWD_EN=1, src_is_branch=0: stall iff k==0 and ld=1 (load-use).
  - FWD_EN=1, src_is_branch=1: stall iff k==0, or (k==1 and ld=1).
- stall is the OR over all sources, forced to 0 while flush=1.
- match_stage is the smallest stalling k across all sources.
- Update priority on each posedge with rst_n=1, highest first:
  1. flush: entries 0..FLUSH_STAGES-1 get vld=0. Older entries shift if pipe_hold=0 and hold otherwise. Issue is ignored.
  2. pipe_hold: all entries hold and nothing is inserted.
  3. Otherwise: entry[k] <= entry[k-1] for k>=1. Entry 0 <= {issue_valid & ~stall, issue_wr_en, issue_wr_reg, issue_is_load}. A stall inserts a bubble (vld=0). The oldest entry drops out.
- With flush=1 and pipe_hold=1 together, the flushed entries clear and the rest hold.
- stall_count increments on posedge when stall=1 & pipe_hold=0. It saturates at all-ones (no wrap). It is cleared only by reset.
- Latency:
  - A newly issued writer is visible to the next decode instruction one cycle after issue.
  - A load-use stall lasts exactly 1 cycle when FWD_EN=1 and there is no hold.
  - With FWD_EN=0, a dependent instruction stalls until the writer leaves entry DEPTH-1, i.e. DEPTH cycles after issue.
- Reset mid-stall: the next cycle has stall=0 and an empty scoreboard.

Test Plan:
- FWD_EN=1: issue load R3, then add reading R3 -> stall=1 for 1 cycle, match_stage=0, then released; stall_count=1.
- FWD_EN=1: issue add R3, then beq reading R3 -> 1-cycle stall. Issue load R3, then beq R3 -> stall=1 for 2 cycles (k=0, then k=1).
- Supersede: load R5 followed by add writing R5, then add reading R5 (FWD_EN=1) -> no stall, because the youngest writer is not a load.
- FWD_EN=0, DEPTH=3: add R2, then reader of R2 -> stall=1 for 3 cycles, match_stage 0,1,2, then issue.
- Load R1, then reader of R1 with flush=1 the same cycle -> stall=0. Next cycle the scoreboard has entry 0 vld=0 and no stall.
- pipe_hold=1 for 4 cycles during a load-use stall -> entries frozen, stall stays 1, stall_count unchanged. Preload stall_count to all-ones then stall -> stays all-ones. rst_n=0 -> stall_count=0, stall=0.

Source files
------------

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : RAW hazard checker for the instruction in decode. It keeps a
//               shift-register scoreboard of in-flight register writes for the
//               DEPTH stages after decode (entry 0 = EX, youngest). Every
//               source operand is compared against its youngest matching
//               writer, and the hits are reduced to a single stall.
//               Supported features:
//                 - forwarding (FWD_EN=1) and non-forwarding pipelines
//                 - early-resolving branch operands
//                 - flush of the youngest entries
//                 - downstream hold
//                 - a saturating count of stall cycles
// Ports       : clk, rst_n (sync, active-low)
//               issue_valid/issue_wr_en/issue_wr_reg/issue_is_load : decode insn
//               src_valid[NUM_SRC], src_reg[NUM_SRC*REG_ADDR_W]    : operands
//               src_is_branch : operands are needed in decode
//               flush, pipe_hold : pipeline control
//               stall (comb), match_stage (comb), stall_count (reg)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 3,
    parameter int NUM_SRC      = 2,
    parameter int DEPTH        = 3,
    parameter int FWD_EN       = 1,
    parameter int FLUSH_STAGES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    issue_valid,
    input  logic                                    issue_wr_en,
    input  logic [REG_ADDR_W-1:0]                   issue_wr_reg,
    input  logic                                    issue_is_load,
    input  logic [NUM_SRC-1:0]                      src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]           src_reg,
    input  logic                                    src_is_branch,
    input  logic                                    flush,
    input  logic                                    pipe_hold,
    output logic                                    stall,
    output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] match_stage,
    output logic [CNT_W-1:0]                        stall_count
);

    localparam int c_ms_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Scoreboard entries {vld, wr, reg, ld}
    logic                  r_vld [DEPTH];
    logic                  r_wr  [DEPTH];
    logic [REG_ADDR_W-1:0] r_reg [DEPTH];
    logic                  r_ld  [DEPTH];
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_hit       [NUM_SRC];
    logic [c_ms_w-1:0]     w_k         [NUM_SRC];
    logic                  w_src_stall [NUM_SRC];
    logic                  w_any;
    logic [c_ms_w-1:0]     w_ms;
    logic                  w_stall;

    always_comb begin
        w_any = 1'b0;
        w_ms  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_hit[i]       = 1'b0;
            w_k[i]         = '0;
            w_src_stall[i] = 1'b0;
            // Walk from oldest to youngest so the youngest writer wins:
            // a newer write to the same register supersedes older ones.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (src_valid[i] && r_vld[k] && r_wr[k] &&
                    (r_reg[k] == src_reg[i*REG_ADDR_W +: REG_ADDR_W])) begin
                    w_hit[i] = 1'b1;
                    w_k[i]   = c_ms_w'(k);
                end
            end
            if (FWD_EN == 0) begin
                w_src_stall[i] = w_hit[i];
            end else if (!src_is_branch) begin
                // Only a load in EX cannot be forwarded in time
                w_src_stall[i] = w_hit[i] && (w_k[i] == '0) && r_ld[w_k[i]];
            end else begin
                // Branch operands are consumed in decode: any EX result is
                // too late, and a load one stage further is still too late.
                w_src_stall[i] = w_hit[i] &&
                                 ((w_k[i] == '0) ||
                                  ((w_k[i] == c_ms_w'(1)) && r_ld[w_k[i]]));
            end
            if (w_src_stall[i] && (!w_any || (w_k[i] < w_ms))) begin
                w_ms  = w_k[i];
                w_any = 1'b1;
            end
        end
        w_stall = w_any && !flush;
    end

    assign stall       = w_stall;
    assign match_stage = w_stall ? w_ms : '0;
    assign stall_count = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_vld[k] <= 1'b0;
            end
            r_cnt <= '0;
        end else begin
            // Older entries advance whenever downstream is not frozen,
            // including during a flush.
            if (!pipe_hold) begin
                for (int k = 1; k < DEPTH; k++) begin
                    r_vld[k] <= r_vld[k-1];
                    r_wr[k]  <= r_wr[k-1];
                    r_reg[k] <= r_reg[k-1];
                    r_ld[k]  <= r_ld[k-1];
                end
            end
            // A stalled decode enters as a bubble
            if (!pipe_hold && !flush) begin
                r_vld[0] <= issue_valid && !w_stall;
                r_wr[0]  <= issue_wr_en;
                r_reg[0] <= issue_wr_reg;
                r_ld[0]  <= issue_is_load;
            end
            // Flush overrides the shift for the youngest entries
            if (flush) begin
                for (int k = 0; (k < FLUSH_STAGES) && (k < DEPTH); k++) begin
                    r_vld[k] <= 1'b0;
                end
            end
            if (w_stall && !pipe_hold && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed bench for hazard_scoreboard. Two instances share the
//               stimulus:
//                 - dut_f : forwarding, 4-bit counter so saturation is reachable
//                 - dut_n : non-forwarding
//               Expected results are queued as each step is driven and then
//               popped and compared at the following negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_wr_en, issue_is_load;
    logic [2:0] issue_wr_reg;
    logic [1:0] src_valid;
    logic [5:0] src_reg;
    logic       src_is_branch, flush, pipe_hold;

    logic        stall_f, stall_n;
    logic [1:0]  ms_f, ms_n;
    logic [3:0]  cnt_f;
    logic [15:0] cnt_n;

    int n_cmp = 0;
    int n_bad = 0;
    int c;

    typedef struct {
        logic       s;
        logic [1:0] ms;
        int         cnt;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .FWD_EN(1),
        .FLUSH_STAGES(1), .CNT_W(4)
    ) dut_f (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
        .issue_wr_reg(issue_wr_reg), .issue_is_load(issue_is_load),
        .src_valid(src_valid), .src_reg(src_reg), .src_is_branch(src_is_branch),
        .flush(flush), .pipe_hold(pipe_hold),
        .stall(stall_f), .match_stage(ms_f), .stall_count(cnt_f)
    );

    hazard_scoreboard #(
        .REG_ADDR_W(3), .NUM_SRC(2), .DEPTH(3), .FWD_EN(0),
        .FLUSH_STAGES(1), .CNT_W(16)
    ) dut_n (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_wr_en(issue_wr_en),
        .issue_wr_reg(issue_wr_reg), .issue_is_load(issue_is_load),
        .src_valid(src_valid), .src_reg(src_reg), .src_is_branch(src_is_branch),
        .flush(flush), .pipe_hold(pipe_hold),
        .stall(stall_n), .match_stage(ms_n), .stall_count(cnt_n)
    );

    task automatic drive(input logic v, input logic wr, input logic [2:0] rg,
                         input logic ld, input logic [1:0] sv,
                         input logic [2:0] s1, input logic [2:0] s0,
                         input logic br, input logic fl, input logic hd);
        issue_valid   = v;
        issue_wr_en   = wr;
        issue_wr_reg  = rg;
        issue_is_load = ld;
        src_valid     = sv;
        src_reg       = {s1, s0};
        src_is_branch = br;
        flush         = fl;
        pipe_hold     = hd;
    endtask

    // Queue the expectation, sample at negedge, then advance one clock
    task automatic check(input string tag, input bit sel_n, input logic es,
                         input logic [1:0] ems, input int ecnt);
        exp_t e;
        logic       os;
        logic [1:0] oms;
        int         ocnt;
        q.push_back('{s: es, ms: ems, cnt: ecnt});
        @(negedge clk);
        e    = q.pop_front();
        os   = sel_n ? stall_n : stall_f;
        oms  = sel_n ? ms_n : ms_f;
        ocnt = sel_n ? int'(cnt_n) : int'(cnt_f);
        n_cmp++;
        assert (os === e.s) else begin
            n_bad++;
            $error("FAIL %s stall observed=%0b expected=%0b", tag, os, e.s);
        end
        n_cmp++;
        assert (oms === e.ms) else begin
            n_bad++;
            $error("FAIL %s match_stage observed=%0d expected=%0d", tag, oms, e.ms);
        end
        n_cmp++;
        assert (ocnt === e.cnt) else begin
            n_bad++;
            $error("FAIL %s stall_count observed=%0d expected=%0d", tag, ocnt, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 3'd0, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- forwarding instance ----------------
        idle();                                                   check("f_reset", 0, 0, 0, 0);
        // load R3 then add reading R3: one-cycle load-use stall
        drive(1, 1, 3'd3, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r3", 0, 0, 0, 0);
        drive(1, 1, 3'd4, 0, 2'b01, 3'd0, 3'd3, 0, 0, 0);         check("lu_stall", 0, 1, 0, 0);
        drive(1, 1, 3'd4, 0, 2'b01, 3'd0, 3'd3, 0, 0, 0);         check("lu_release", 0, 0, 0, 1);
        idle();                                                   check("f_idle1", 0, 0, 0, 1);
        // add R3 then beq R3 (source 1): one-cycle branch stall
        drive(1, 1, 3'd3, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("add_r3", 0, 0, 0, 1);
        drive(1, 0, 3'd0, 0, 2'b10, 3'd3, 3'd0, 1, 0, 0);         check("br_alu_k0", 0, 1, 0, 1);
        drive(1, 0, 3'd0, 0, 2'b10, 3'd3, 3'd0, 1, 0, 0);         check("br_alu_rel", 0, 0, 0, 2);
        // load R3 then beq R3: two-cycle stall, k=0 then k=1
        drive(1, 1, 3'd3, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r3b", 0, 0, 0, 2);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd3, 1, 0, 0);         check("br_ld_k0", 0, 1, 0, 2);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd3, 1, 0, 0);         check("br_ld_k1", 0, 1, 1, 3);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd3, 1, 0, 0);         check("br_ld_rel", 0, 0, 0, 4);
        // supersede: load R5, add R5, reader R5 -> no stall
        drive(1, 1, 3'd5, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r5", 0, 0, 0, 4);
        drive(1, 1, 3'd5, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("add_r5", 0, 0, 0, 4);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd5, 0, 0, 0);         check("supersede", 0, 0, 0, 4);
        idle();                                                   check("f_idle2", 0, 0, 0, 4);
        // flush during a load-use hazard
        drive(1, 1, 3'd1, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r1", 0, 0, 0, 4);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd1, 0, 1, 0);         check("flush_mask", 0, 0, 0, 4);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd1, 0, 0, 0);         check("post_flush", 0, 0, 0, 4);
        // hold for 4 cycles during a load-use stall
        drive(1, 1, 3'd6, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r6", 0, 0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd6, 0, 0, 1);     check("hold_stall", 0, 1, 0, 4);
        end
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd6, 0, 0, 0);         check("hold_end", 0, 1, 0, 4);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd6, 0, 0, 0);         check("hold_rel", 0, 0, 0, 5);
        // drive the 4-bit counter into saturation
        c = 5;
        for (int i = 0; i < 11; i++) begin
            drive(1, 1, 3'd7, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);     check("sat_ld", 0, 0, 0, c);
            drive(1, 0, 3'd0, 0, 2'b11, 3'd7, 3'd7, 0, 0, 0);     check("sat_stall", 0, 1, 0, c);
            c = (c < 15) ? c + 1 : 15;
            drive(1, 0, 3'd0, 0, 2'b11, 3'd7, 3'd7, 0, 0, 0);     check("sat_rel", 0, 0, 0, c);
        end
        // reset in the middle of a stall
        drive(1, 1, 3'd2, 1, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("ld_r2", 0, 0, 0, 15);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("pre_rst", 0, 1, 0, 15);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("mid_rst", 0, 0, 0, 0);

        // ---------------- non-forwarding instance ----------------
        do_reset();
        idle();                                                   check("n_reset", 1, 0, 0, 0);
        drive(1, 1, 3'd2, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("n_add_r2", 1, 0, 0, 0);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("n_k0", 1, 1, 0, 0);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("n_k1", 1, 1, 1, 1);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("n_k2", 1, 1, 2, 2);
        drive(1, 0, 3'd0, 0, 2'b01, 3'd0, 3'd2, 0, 0, 0);         check("n_rel", 1, 0, 0, 3);
        // two sources, match_stage is the youngest stalling entry
        drive(1, 1, 3'd1, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("n_add_r1", 1, 0, 0, 3);
        drive(1, 1, 3'd2, 0, 2'b00, 3'd0, 3'd0, 0, 0, 0);         check("n_add_r2b", 1, 0, 0, 3);
        drive(1, 0, 3'd0, 0, 2'b11, 3'd2, 3'd1, 0, 0, 0);         check("n_two_k0", 1, 1, 0, 3);
        drive(1, 0, 3'd0, 0, 2'b11, 3'd2, 3'd1, 0, 0, 0);         check("n_two_k1", 1, 1, 1, 4);
        drive(1, 0, 3'd0, 0, 2'b11, 3'd2, 3'd1, 0, 0, 0);         check("n_two_k2", 1, 1, 2, 5);
        drive(1, 0, 3'd0, 0, 2'b11, 3'd2, 3'd1, 0, 0, 0);         check("n_two_rel", 1, 0, 0, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
